// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: commit-stage exception/interrupt controller.
// Merges slot0/slot1 commit exceptions, pending interrupts and ERET into at
// most one CP0 event per cycle, then sequences redirect and pipeline flush.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | commits accepted; one event may be raised this cycle
// REDIR | one-cycle redirect pulse to the fetch unit
// DRAIN | flush held until the pipeline reports empty (drain_done)
module cp0_exc_ctrl #(
  parameter int          CNT_W      = 16,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [1:0]       cm_valid,
  input  logic [31:0]      cm_pc0,
  input  logic [31:0]      cm_pc1,
  input  logic [1:0]       cm_exc,
  input  logic [4:0]       cm_code0,
  input  logic [4:0]       cm_code1,
  input  logic [31:0]      cm_badva0,
  input  logic [31:0]      cm_badva1,
  input  logic [1:0]       cm_bd,
  input  logic [1:0]       cm_eret,
  input  logic             st_exl,
  input  logic             st_ie,
  input  logic [7:0]       st_im,
  input  logic [7:0]       ca_ip,
  input  logic [31:0]      cp0_epc,
  input  logic             drain_done,
  output logic             commit_ready,
  output logic             exception_en,
  output logic             exc_bd,
  output logic [4:0]       exc_code,
  output logic [31:0]      exc_epc,
  output logic [31:0]      exc_badva,
  output logic             eret,
  output logic             kill_slot1,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] exc_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REDIR = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t      state;
  state_t      state_nxt;
  logic        int_raw;
  logic        int_q;
  logic        ev_any;
  logic [31:0] rpc_nxt;
  logic [31:0] epc_s0;
  logic [31:0] epc_s1;

  // An interrupt is pending only when enabled and not already in exception level.
  assign int_raw = (|(st_im & ca_ip)) & st_ie & ~st_exl;

  // A delay-slot instruction restarts at its branch, one word earlier.
  assign epc_s0 = cm_bd[0] ? (cm_pc0 - 32'd4) : cm_pc0;
  assign epc_s1 = cm_bd[1] ? (cm_pc1 - 32'd4) : cm_pc1;

  // Event selection (interrupt > slot0 exc > slot0 eret > slot1 exc > slot1 eret) and next state.
  always_comb begin
    state_nxt    = state;
    commit_ready = 1'b0;
    exception_en = 1'b0;
    exc_bd       = 1'b0;
    exc_code     = 5'h00;
    exc_epc      = 32'h0;
    exc_badva    = 32'h0;
    eret         = 1'b0;
    kill_slot1   = 1'b0;
    ev_any       = 1'b0;
    rpc_nxt      = 32'h0;

    case (state)
      IDLE: begin
        commit_ready = 1'b1;
        // int_raw is re-checked so an MTC0 that just cleared the source wins.
        if (int_q && cm_valid[0] && int_raw) begin
          exception_en = 1'b1;
          exc_code     = 5'h00;
          exc_epc      = epc_s0;
          exc_bd       = cm_bd[0];
          kill_slot1   = 1'b1;
          ev_any       = 1'b1;
          rpc_nxt      = EXC_VECTOR;
        end else if (cm_valid[0] && cm_exc[0]) begin
          exception_en = 1'b1;
          exc_code     = cm_code0;
          exc_badva    = cm_badva0;
          exc_epc      = epc_s0;
          exc_bd       = cm_bd[0];
          kill_slot1   = 1'b1;
          ev_any       = 1'b1;
          rpc_nxt      = EXC_VECTOR;
        end else if (cm_valid[0] && cm_eret[0]) begin
          eret         = 1'b1;
          exc_epc      = epc_s0;
          exc_bd       = cm_bd[0];
          kill_slot1   = 1'b1;
          ev_any       = 1'b1;
          rpc_nxt      = cp0_epc;
        end else if (cm_valid[1] && cm_exc[1]) begin
          exception_en = 1'b1;
          exc_code     = cm_code1;
          exc_badva    = cm_badva1;
          exc_epc      = epc_s1;
          exc_bd       = cm_bd[1];
          ev_any       = 1'b1;
          rpc_nxt      = EXC_VECTOR;
        end else if (cm_valid[1] && cm_eret[1]) begin
          eret         = 1'b1;
          exc_epc      = epc_s1;
          exc_bd       = cm_bd[1];
          ev_any       = 1'b1;
          rpc_nxt      = cp0_epc;
        end
        if (ev_any) state_nxt = REDIR;
      end
      REDIR: state_nxt = DRAIN;
      DRAIN: if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs stay quiet for the whole reset cycle.
    if (!resetn) begin
      state_nxt    = IDLE;
      commit_ready = 1'b0;
      exception_en = 1'b0;
      exc_bd       = 1'b0;
      exc_code     = 5'h00;
      exc_epc      = 32'h0;
      exc_badva    = 32'h0;
      eret         = 1'b0;
      kill_slot1   = 1'b0;
      ev_any       = 1'b0;
      rpc_nxt      = 32'h0;
    end
  end

  // State register and one-cycle interrupt qualification.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      int_q <= 1'b0;
    end else begin
      state <= state_nxt;
      int_q <= int_raw;
    end
  end

  // Redirect pulse in REDIR; flush covers every non-IDLE cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
      flush          <= 1'b0;
    end else begin
      redirect_valid <= ev_any;
      redirect_pc    <= ev_any ? rpc_nxt : 32'h0;
      flush          <= (state_nxt != IDLE);
    end
  end

  // Saturating count of taken exceptions and interrupts.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      exc_cnt <= '0;
    end else if (exception_en && (exc_cnt != CNT_MAX)) begin
      exc_cnt <= exc_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl. A second, narrow-counter instance shares
// the stimulus so counter saturation is reachable in a short run.
module tb_cp0_exc_ctrl;

  logic        clk;
  logic        resetn;
  logic [1:0]  cm_valid;
  logic [31:0] cm_pc0, cm_pc1;
  logic [1:0]  cm_exc;
  logic [4:0]  cm_code0, cm_code1;
  logic [31:0] cm_badva0, cm_badva1;
  logic [1:0]  cm_bd, cm_eret;
  logic        st_exl, st_ie;
  logic [7:0]  st_im, ca_ip;
  logic [31:0] cp0_epc;
  logic        drain_done;

  logic        commit_ready, exception_en, exc_bd, eret, kill_slot1;
  logic        redirect_valid, flush;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc, exc_badva, redirect_pc;
  logic [15:0] exc_cnt;

  logic        s_commit_ready, s_exception_en, s_exc_bd, s_eret, s_kill_slot1;
  logic        s_redirect_valid, s_flush;
  logic [4:0]  s_exc_code;
  logic [31:0] s_exc_epc, s_exc_badva, s_redirect_pc;
  logic [3:0]  s_exc_cnt;

  int checks   = 0;
  int failures = 0;

  cp0_exc_ctrl dut (
    .clk(clk), .resetn(resetn), .cm_valid(cm_valid), .cm_pc0(cm_pc0), .cm_pc1(cm_pc1),
    .cm_exc(cm_exc), .cm_code0(cm_code0), .cm_code1(cm_code1),
    .cm_badva0(cm_badva0), .cm_badva1(cm_badva1), .cm_bd(cm_bd), .cm_eret(cm_eret),
    .st_exl(st_exl), .st_ie(st_ie), .st_im(st_im), .ca_ip(ca_ip), .cp0_epc(cp0_epc),
    .drain_done(drain_done), .commit_ready(commit_ready), .exception_en(exception_en),
    .exc_bd(exc_bd), .exc_code(exc_code), .exc_epc(exc_epc), .exc_badva(exc_badva),
    .eret(eret), .kill_slot1(kill_slot1), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .exc_cnt(exc_cnt)
  );

  cp0_exc_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .resetn(resetn), .cm_valid(cm_valid), .cm_pc0(cm_pc0), .cm_pc1(cm_pc1),
    .cm_exc(cm_exc), .cm_code0(cm_code0), .cm_code1(cm_code1),
    .cm_badva0(cm_badva0), .cm_badva1(cm_badva1), .cm_bd(cm_bd), .cm_eret(cm_eret),
    .st_exl(st_exl), .st_ie(st_ie), .st_im(st_im), .ca_ip(ca_ip), .cp0_epc(cp0_epc),
    .drain_done(drain_done), .commit_ready(s_commit_ready), .exception_en(s_exception_en),
    .exc_bd(s_exc_bd), .exc_code(s_exc_code), .exc_epc(s_exc_epc), .exc_badva(s_exc_badva),
    .eret(s_eret), .kill_slot1(s_kill_slot1), .redirect_valid(s_redirect_valid),
    .redirect_pc(s_redirect_pc), .flush(s_flush), .exc_cnt(s_exc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_cm();
    cm_valid  = 2'b00; cm_exc = 2'b00; cm_eret = 2'b00; cm_bd = 2'b00;
    cm_pc0    = 32'h0; cm_pc1 = 32'h0;
    cm_code0  = 5'h0;  cm_code1 = 5'h0;
    cm_badva0 = 32'h0; cm_badva1 = 32'h0;
  endtask

  // Call while in REDIR: drain in one DRAIN cycle and return to IDLE.
  task automatic drain_out();
    clear_cm();
    drain_done = 1'b1;
    tick();
    tick();
    drain_done = 1'b0;
  endtask

  task automatic take_exc();
    cm_valid = 2'b01; cm_exc = 2'b01; cm_code0 = 5'h0C; cm_pc0 = 32'h8000_0100;
    tick();
    drain_out();
  endtask

  initial begin
    resetn = 1'b0; drain_done = 1'b0; cp0_epc = 32'h0;
    st_exl = 1'b0; st_ie = 1'b0; st_im = 8'h0; ca_ip = 8'h0;
    clear_cm();
    tick();
    tick();
    // outputs forced quiet during reset even with an exception presented
    cm_valid = 2'b01; cm_exc = 2'b01;
    settle();
    check_val("rst_exc_en", {31'h0, exception_en}, 32'h0);
    check_val("rst_kill", {31'h0, kill_slot1}, 32'h0);
    tick();
    clear_cm();
    resetn = 1'b1;
    settle();
    check_val("rst_commit_ready", {31'h0, commit_ready}, 32'h1);
    check_val("rst_flush", {31'h0, flush}, 32'h0);
    check_val("rst_redir_valid", {31'h0, redirect_valid}, 32'h0);
    check_val("rst_redir_pc", redirect_pc, 32'h0);
    check_val("rst_cnt", {16'h0, exc_cnt}, 32'h0);

    // slot0 AdEL
    cm_valid = 2'b11; cm_exc = 2'b01; cm_code0 = 5'h04; cm_badva0 = 32'h1;
    cm_pc0 = 32'hBFC0_0100;
    settle();
    check_val("s0_exc_en", {31'h0, exception_en}, 32'h1);
    check_val("s0_code", {27'h0, exc_code}, 32'h4);
    check_val("s0_epc", exc_epc, 32'hBFC0_0100);
    check_val("s0_badva", exc_badva, 32'h1);
    check_val("s0_kill", {31'h0, kill_slot1}, 32'h1);
    check_val("s0_eret", {31'h0, eret}, 32'h0);
    tick();
    clear_cm();
    drain_done = 1'b1;   // must be ignored in REDIR
    settle();
    check_val("s0_redir_valid", {31'h0, redirect_valid}, 32'h1);
    check_val("s0_redir_pc", redirect_pc, 32'hBFC0_0380);
    check_val("s0_redir_flush", {31'h0, flush}, 32'h1);
    check_val("s0_redir_cr", {31'h0, commit_ready}, 32'h0);
    tick();
    check_val("s0_drain_flush", {31'h0, flush}, 32'h1);
    check_val("s0_drain_rv", {31'h0, redirect_valid}, 32'h0);
    check_val("s0_drain_cr", {31'h0, commit_ready}, 32'h0);
    tick();
    drain_done = 1'b0;
    check_val("s0_idle_cr", {31'h0, commit_ready}, 32'h1);
    check_val("s0_idle_flush", {31'h0, flush}, 32'h0);
    check_val("s0_cnt", {16'h0, exc_cnt}, 32'd1);

    // slot1 exception in delay slot
    cm_valid = 2'b11; cm_exc = 2'b10; cm_bd = 2'b10; cm_pc1 = 32'h8000_0024;
    cm_code1 = 5'h0C; cm_badva1 = 32'h55;
    settle();
    check_val("s1_exc_en", {31'h0, exception_en}, 32'h1);
    check_val("s1_epc", exc_epc, 32'h8000_0020);
    check_val("s1_bd", {31'h0, exc_bd}, 32'h1);
    check_val("s1_kill", {31'h0, kill_slot1}, 32'h0);
    check_val("s1_code", {27'h0, exc_code}, 32'hC);
    check_val("s1_badva", exc_badva, 32'h55);
    tick();
    settle();
    check_val("s1_redir_pc", redirect_pc, 32'hBFC0_0380);
    drain_out();
    check_val("s1_cnt", {16'h0, exc_cnt}, 32'd2);

    // timer interrupt beats a simultaneous slot0 exception
    ca_ip = 8'h80; st_im = 8'h80; st_ie = 1'b1; st_exl = 1'b0;
    tick();
    tick();
    cm_valid = 2'b01; cm_exc = 2'b01; cm_code0 = 5'h04; cm_badva0 = 32'h77;
    cm_pc0 = 32'hBFC0_0200;
    settle();
    check_val("int_exc_en", {31'h0, exception_en}, 32'h1);
    check_val("int_code", {27'h0, exc_code}, 32'h0);
    check_val("int_badva", exc_badva, 32'h0);
    check_val("int_epc", exc_epc, 32'hBFC0_0200);
    check_val("int_kill", {31'h0, kill_slot1}, 32'h1);
    tick();
    drain_out();
    check_val("int_cnt", {16'h0, exc_cnt}, 32'd3);

    // EXL masks the interrupt
    st_exl = 1'b1;
    tick();
    tick();
    cm_valid = 2'b01;
    settle();
    check_val("int_exl_none", {31'h0, exception_en}, 32'h0);
    tick();
    check_val("int_exl_flush", {31'h0, flush}, 32'h0);

    // request withdrawn in the commit cycle is dropped
    clear_cm();
    st_exl = 1'b0;
    tick();
    tick();
    ca_ip = 8'h00;
    cm_valid = 2'b01;
    settle();
    check_val("int_withdrawn", {31'h0, exception_en}, 32'h0);
    tick();
    clear_cm();
    st_ie = 1'b0; st_im = 8'h0;

    // slot0 ERET
    cm_valid = 2'b01; cm_eret = 2'b01; cp0_epc = 32'h8000_1000;
    settle();
    check_val("eret0_eret", {31'h0, eret}, 32'h1);
    check_val("eret0_exc_en", {31'h0, exception_en}, 32'h0);
    check_val("eret0_kill", {31'h0, kill_slot1}, 32'h1);
    tick();
    cp0_epc = 32'h0;
    settle();
    check_val("eret0_redir_valid", {31'h0, redirect_valid}, 32'h1);
    check_val("eret0_redir_pc", redirect_pc, 32'h8000_1000);
    drain_out();
    check_val("eret0_cnt", {16'h0, exc_cnt}, 32'd3);

    // slot1 ERET
    cm_valid = 2'b11; cm_eret = 2'b10; cp0_epc = 32'h8000_2000;
    settle();
    check_val("eret1_eret", {31'h0, eret}, 32'h1);
    check_val("eret1_kill", {31'h0, kill_slot1}, 32'h0);
    tick();
    settle();
    check_val("eret1_redir_pc", redirect_pc, 32'h8000_2000);
    drain_out();

    // long drain: exceptions presented meanwhile are ignored
    cm_valid = 2'b01; cm_exc = 2'b01; cm_code0 = 5'h05;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      settle();
      check_val("ldrain_flush", {31'h0, flush}, 32'h1);
      check_val("ldrain_cr", {31'h0, commit_ready}, 32'h0);
      check_val("ldrain_exc_en", {31'h0, exception_en}, 32'h0);
      tick();
    end
    clear_cm();
    drain_done = 1'b1;
    settle();
    check_val("ldrain_last_flush", {31'h0, flush}, 32'h1);
    tick();
    drain_done = 1'b0;
    check_val("ldrain_idle_cr", {31'h0, commit_ready}, 32'h1);
    check_val("ldrain_idle_flush", {31'h0, flush}, 32'h0);
    check_val("ldrain_cnt", {16'h0, exc_cnt}, 32'd4);

    // reset during DRAIN
    cm_valid = 2'b01; cm_exc = 2'b01;
    tick();
    clear_cm();
    tick();
    check_val("rstd_pre_flush", {31'h0, flush}, 32'h1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    settle();
    check_val("rstd_flush", {31'h0, flush}, 32'h0);
    check_val("rstd_cr", {31'h0, commit_ready}, 32'h1);
    check_val("rstd_cnt", {16'h0, exc_cnt}, 32'h0);
    check_val("rstd_rv", {31'h0, redirect_valid}, 32'h0);

    // counter saturation on the narrow instance
    for (int i = 0; i < 14; i++) take_exc();
    check_val("sat_14", {28'h0, s_exc_cnt}, 32'hE);
    take_exc();
    check_val("sat_15", {28'h0, s_exc_cnt}, 32'hF);
    for (int i = 0; i < 5; i++) take_exc();
    check_val("sat_hold", {28'h0, s_exc_cnt}, 32'hF);
    check_val("cnt_20", {16'h0, exc_cnt}, 32'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
